mesi_isc_cpu_port: RTL and testbench

MESI_ISC_CPU_PORT -- requirements
Module: mesi_isc_cpu_port

---
 rtl/mesi_isc_cpu_port_pkg.sv | 37 +++
 rtl/mesi_isc_cpu_port_fifo.sv | 63 ++++++
 rtl/mesi_isc_cpu_port.sv | 212 +++++++++++++++++++++
 tb/tb_mesi_isc_cpu_port.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesi_isc_cpu_port_pkg.sv
// Shared encodings, state enums and default widths for the MESI
// coherence controller CPU port.
package mesi_isc_cpu_port_pkg;

   localparam int MBUS_CMD_W_DEF = 3;
   localparam int CBUS_CMD_W_DEF = 3;
   localparam int ADDR_W_DEF     = 32;
   localparam int FIFO_SIZE_DEF  = 2;
   localparam int FIFO_LOG2_DEF  = 1;
   localparam int SNOOP_LAT_DEF  = 2;

   localparam logic [2:0] MBUS_NOP      = 3'd0;
   localparam logic [2:0] MBUS_WR       = 3'd1;
   localparam logic [2:0] MBUS_RD       = 3'd2;
   localparam logic [2:0] MBUS_WR_BROAD = 3'd3;
   localparam logic [2:0] MBUS_RD_BROAD = 3'd4;

   localparam logic [2:0] CBUS_NOP      = 3'd0;
   localparam logic [2:0] CBUS_WR_SNOOP = 3'd1;
   localparam logic [2:0] CBUS_RD_SNOOP = 3'd2;
   localparam logic [2:0] CBUS_EN_WR    = 3'd3;
   localparam logic [2:0] CBUS_EN_RD    = 3'd4;

   typedef enum logic [1:0] {
      M_IDLE,
      M_REQ,
      M_WAIT_EN
   } main_state_e;

   typedef enum logic [1:0] {
      C_IDLE,
      C_SNOOP,
      C_ACK,
      C_GAP
   } coh_state_e;

endpackage

// File: rtl/mesi_isc_cpu_port_fifo.sv
// CPU request FIFO: registered occupancy, so an entry pushed into an
// empty FIFO only becomes visible at the head one cycle later.
module mesi_isc_cpu_port_fifo
   import mesi_isc_cpu_port_pkg::*;
#(
   parameter int DATA_WIDTH = MBUS_CMD_W_DEF + ADDR_W_DEF,
   parameter int SIZE       = FIFO_SIZE_DEF,
   parameter int SIZE_LOG2  = FIFO_LOG2_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  full_o,
   output logic                  empty_o
);

   logic [DATA_WIDTH-1:0] mem_q [SIZE];
   logic [DATA_WIDTH-1:0] mem_d [SIZE];
   logic [SIZE_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
   logic [SIZE_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
   logic [SIZE_LOG2:0]    count_q, count_d;

   assign full_o  = (count_q == (SIZE_LOG2+1)'(SIZE));
   assign empty_o = (count_q == '0);
   assign data_o  = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d = (wr_ptr_q == SIZE_LOG2'(SIZE-1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
         rd_ptr_d = (rd_ptr_q == SIZE_LOG2'(SIZE-1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SIZE; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/mesi_isc_cpu_port.sv
// CPU-side port of the MESI coherence controller: queues CPU requests,
// issues them on the main bus and services snoop / enable commands.
module mesi_isc_cpu_port
   import mesi_isc_cpu_port_pkg::*;
#(
   parameter int MBUS_CMD_WIDTH     = MBUS_CMD_W_DEF,
   parameter int CBUS_CMD_WIDTH     = CBUS_CMD_W_DEF,
   parameter int ADDR_WIDTH         = ADDR_W_DEF,
   parameter int REQ_FIFO_SIZE      = FIFO_SIZE_DEF,
   parameter int REQ_FIFO_SIZE_LOG2 = FIFO_LOG2_DEF,
   parameter int SNOOP_LAT          = SNOOP_LAT_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cpu_req_valid_i,
   input  logic [MBUS_CMD_WIDTH-1:0] cpu_req_cmd_i,
   input  logic [ADDR_WIDTH-1:0]     cpu_req_addr_i,
   output logic                      cpu_req_ready_o,
   output logic                      cpu_done_o,
   output logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o,
   output logic [ADDR_WIDTH-1:0]     mbus_addr_o,
   input  logic                      mbus_ack_i,
   input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
   input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
   output logic                      cbus_ack_o,
   output logic                      snoop_valid_o,
   output logic                      snoop_wr_o,
   output logic [ADDR_WIDTH-1:0]     snoop_addr_o,
   output logic                      protocol_err_o
);

   localparam int DW    = MBUS_CMD_WIDTH + ADDR_WIDTH;
   localparam int CNT_W = 8;

   localparam logic [MBUS_CMD_WIDTH-1:0] CMD_NOP = MBUS_CMD_WIDTH'(MBUS_NOP);
   localparam logic [MBUS_CMD_WIDTH-1:0] CMD_WRB = MBUS_CMD_WIDTH'(MBUS_WR_BROAD);
   localparam logic [MBUS_CMD_WIDTH-1:0] CMD_RDB = MBUS_CMD_WIDTH'(MBUS_RD_BROAD);
   localparam logic [CBUS_CMD_WIDTH-1:0] CB_WRS  = CBUS_CMD_WIDTH'(CBUS_WR_SNOOP);
   localparam logic [CBUS_CMD_WIDTH-1:0] CB_RDS  = CBUS_CMD_WIDTH'(CBUS_RD_SNOOP);
   localparam logic [CBUS_CMD_WIDTH-1:0] CB_ENW  = CBUS_CMD_WIDTH'(CBUS_EN_WR);
   localparam logic [CBUS_CMD_WIDTH-1:0] CB_ENR  = CBUS_CMD_WIDTH'(CBUS_EN_RD);

   logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [DW-1:0]             fifo_rdata;
   logic [MBUS_CMD_WIDTH-1:0] head_cmd;
   logic [ADDR_WIDTH-1:0]     head_addr;

   main_state_e               m_state_q, m_state_d;
   coh_state_e                c_state_q, c_state_d;
   logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_q, mbus_cmd_d;
   logic [MBUS_CMD_WIDTH-1:0] req_cmd_q, req_cmd_d;
   logic [ADDR_WIDTH-1:0]     mbus_addr_q, mbus_addr_d;
   logic                      cpu_done_q, cpu_done_d;
   logic                      cbus_ack_q, cbus_ack_d;
   logic                      snoop_valid_q, snoop_valid_d;
   logic                      snoop_wr_q, snoop_wr_d;
   logic [ADDR_WIDTH-1:0]     snoop_addr_q, snoop_addr_d;
   logic                      err_q, err_d;
   logic [CNT_W-1:0]          snoop_cnt_q, snoop_cnt_d;

   logic snoop_cmd, en_cmd, en_type_ok, en_hit;

   assign fifo_push = cpu_req_valid_i & ~fifo_full;
   assign head_cmd  = fifo_rdata[DW-1 -: MBUS_CMD_WIDTH];
   assign head_addr = fifo_rdata[ADDR_WIDTH-1:0];

   mesi_isc_cpu_port_fifo #(
      .DATA_WIDTH (DW),
      .SIZE       (REQ_FIFO_SIZE),
      .SIZE_LOG2  (REQ_FIFO_SIZE_LOG2)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .data_i  ({cpu_req_cmd_i, cpu_req_addr_i}),
      .pop_i   (fifo_pop),
      .data_o  (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Enable commands are only sampled when the coherence FSM is idle.
   assign snoop_cmd  = (c_state_q == C_IDLE) &&
                       (cbus_cmd_i == CB_WRS || cbus_cmd_i == CB_RDS);
   assign en_cmd     = (c_state_q == C_IDLE) &&
                       (cbus_cmd_i == CB_ENW || cbus_cmd_i == CB_ENR);
   assign en_type_ok = (cbus_cmd_i == CB_ENW && req_cmd_q == CMD_WRB) ||
                       (cbus_cmd_i == CB_ENR && req_cmd_q == CMD_RDB);
   assign en_hit     = en_cmd && en_type_ok &&
                       (m_state_q == M_WAIT_EN) &&
                       (cbus_addr_i == mbus_addr_q);

   always_comb begin
      m_state_d   = m_state_q;
      mbus_cmd_d  = mbus_cmd_q;
      mbus_addr_d = mbus_addr_q;
      req_cmd_d   = req_cmd_q;
      cpu_done_d  = 1'b0;
      fifo_pop    = 1'b0;
      unique case (m_state_q)
         M_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop    = 1'b1;
               mbus_cmd_d  = head_cmd;
               mbus_addr_d = head_addr;
               req_cmd_d   = head_cmd;
               m_state_d   = M_REQ;
            end
         end
         M_REQ: begin
            if (mbus_ack_i) begin
               mbus_cmd_d = CMD_NOP;
               if (req_cmd_q == CMD_WRB || req_cmd_q == CMD_RDB) begin
                  m_state_d = M_WAIT_EN;
               end else begin
                  cpu_done_d = 1'b1;
                  m_state_d  = M_IDLE;
               end
            end
         end
         M_WAIT_EN: begin
            if (en_hit) begin
               cpu_done_d = 1'b1;
               m_state_d  = M_IDLE;
            end
         end
         default: m_state_d = M_IDLE;
      endcase
   end

   always_comb begin
      c_state_d     = c_state_q;
      cbus_ack_d    = 1'b0;
      snoop_valid_d = 1'b0;
      snoop_wr_d    = snoop_wr_q;
      snoop_addr_d  = snoop_addr_q;
      snoop_cnt_d   = snoop_cnt_q;
      err_d         = err_q | (cpu_req_valid_i & fifo_full) |
                      (en_cmd & ~en_hit);
      unique case (c_state_q)
         C_IDLE: begin
            if (snoop_cmd) begin
               snoop_valid_d = 1'b1;
               snoop_wr_d    = (cbus_cmd_i == CB_WRS);
               snoop_addr_d  = cbus_addr_i;
               snoop_cnt_d   = '0;
               if (SNOOP_LAT <= 1) begin
                  c_state_d  = C_ACK;
                  cbus_ack_d = 1'b1;
               end else begin
                  c_state_d  = C_SNOOP;
               end
            end else if (en_cmd) begin
               c_state_d  = C_ACK;
               cbus_ack_d = 1'b1;
            end
         end
         C_SNOOP: begin
            if (snoop_cnt_q == CNT_W'(SNOOP_LAT - 2)) begin
               c_state_d  = C_ACK;
               cbus_ack_d = 1'b1;
            end else begin
               snoop_cnt_d = snoop_cnt_q + 1'b1;
            end
         end
         C_ACK:   c_state_d = C_GAP;
         C_GAP:   c_state_d = C_IDLE;
         default: c_state_d = C_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_state_q     <= M_IDLE;
         c_state_q     <= C_IDLE;
         mbus_cmd_q    <= CMD_NOP;
         mbus_addr_q   <= '0;
         req_cmd_q     <= CMD_NOP;
         cpu_done_q    <= 1'b0;
         cbus_ack_q    <= 1'b0;
         snoop_valid_q <= 1'b0;
         snoop_wr_q    <= 1'b0;
         snoop_addr_q  <= '0;
         err_q         <= 1'b0;
         snoop_cnt_q   <= '0;
      end else begin
         m_state_q     <= m_state_d;
         c_state_q     <= c_state_d;
         mbus_cmd_q    <= mbus_cmd_d;
         mbus_addr_q   <= mbus_addr_d;
         req_cmd_q     <= req_cmd_d;
         cpu_done_q    <= cpu_done_d;
         cbus_ack_q    <= cbus_ack_d;
         snoop_valid_q <= snoop_valid_d;
         snoop_wr_q    <= snoop_wr_d;
         snoop_addr_q  <= snoop_addr_d;
         err_q         <= err_d;
         snoop_cnt_q   <= snoop_cnt_d;
      end
   end

   assign cpu_req_ready_o = ~fifo_full;
   assign cpu_done_o      = cpu_done_q;
   assign mbus_cmd_o      = mbus_cmd_q;
   assign mbus_addr_o     = mbus_addr_q;
   assign cbus_ack_o      = cbus_ack_q;
   assign snoop_valid_o   = snoop_valid_q;
   assign snoop_wr_o      = snoop_wr_q;
   assign snoop_addr_o    = snoop_addr_q;
   assign protocol_err_o  = err_q;

endmodule

// File: tb/tb_mesi_isc_cpu_port.sv
// Randomised + directed bench for mesi_isc_cpu_port against a
// transaction-level model built on a queue and absolute cycle times.
module tb_mesi_isc_cpu_port;

   localparam int L     = 2;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cpu_req_valid_i = 1'b0;
   logic [2:0]  cpu_req_cmd_i = '0;
   logic [31:0] cpu_req_addr_i = '0;
   logic        cpu_req_ready_o, cpu_done_o;
   logic [2:0]  mbus_cmd_o;
   logic [31:0] mbus_addr_o;
   logic        mbus_ack_i = 1'b0;
   logic [2:0]  cbus_cmd_i = '0;
   logic [31:0] cbus_addr_i = '0;
   logic        cbus_ack_o, snoop_valid_o, snoop_wr_o, protocol_err_o;
   logic [31:0] snoop_addr_o;

   mesi_isc_cpu_port #(
      .MBUS_CMD_WIDTH(3), .CBUS_CMD_WIDTH(3), .ADDR_WIDTH(32),
      .REQ_FIFO_SIZE(DEPTH), .REQ_FIFO_SIZE_LOG2(1), .SNOOP_LAT(L)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_req_valid_i(cpu_req_valid_i), .cpu_req_cmd_i(cpu_req_cmd_i),
      .cpu_req_addr_i(cpu_req_addr_i), .cpu_req_ready_o(cpu_req_ready_o),
      .cpu_done_o(cpu_done_o), .mbus_cmd_o(mbus_cmd_o),
      .mbus_addr_o(mbus_addr_o), .mbus_ack_i(mbus_ack_i),
      .cbus_cmd_i(cbus_cmd_i), .cbus_addr_i(cbus_addr_i),
      .cbus_ack_o(cbus_ack_o), .snoop_valid_o(snoop_valid_o),
      .snoop_wr_o(snoop_wr_o), .snoop_addr_o(snoop_addr_o),
      .protocol_err_o(protocol_err_o)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit run_cmp = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [2:0]  cmd;
      logic [31:0] addr;
   } req_t;

   req_t        mq[$];
   req_t        cur;
   int          m_phase;
   longint      cyc, ack_edge, accept_edge;
   logic [2:0]  e_mcmd;
   logic [31:0] e_maddr, e_saddr;
   bit          e_done, e_ack, e_sv, e_swr, e_err, e_ready;

   task automatic model_reset();
      mq.delete();
      m_phase = 0;
      cur = '{cmd: 3'd0, addr: 32'd0};
      ack_edge = -1;
      accept_edge = 0;
      e_mcmd = 3'd0; e_maddr = '0; e_saddr = '0;
      e_done = 0; e_ack = 0; e_sv = 0; e_swr = 0; e_err = 0; e_ready = 1;
   endtask

   task automatic model_step();
      bit     en_ok, done;
      int     pre_size;
      en_ok = 0;
      done  = 0;
      cyc++;
      e_sv = 0;
      if (cyc >= accept_edge) begin
         if (cbus_cmd_i == 3'd1 || cbus_cmd_i == 3'd2) begin
            e_sv = 1;
            e_swr = (cbus_cmd_i == 3'd1);
            e_saddr = cbus_addr_i;
            ack_edge = cyc + L - 1;
            accept_edge = ack_edge + 3;
         end else if (cbus_cmd_i == 3'd3 || cbus_cmd_i == 3'd4) begin
            ack_edge = cyc;
            accept_edge = cyc + 3;
            en_ok = (m_phase == 2) && (cbus_addr_i == cur.addr) &&
                    ((cbus_cmd_i == 3'd3 && cur.cmd == 3'd3) ||
                     (cbus_cmd_i == 3'd4 && cur.cmd == 3'd4));
            if (!en_ok) e_err = 1;
         end
      end
      e_ack = (cyc == ack_edge);
      pre_size = mq.size();
      case (m_phase)
         0: if (pre_size > 0) begin
               cur = mq.pop_front();
               m_phase = 1;
               e_mcmd = cur.cmd;
               e_maddr = cur.addr;
            end
         1: if (mbus_ack_i) begin
               e_mcmd = 3'd0;
               if (cur.cmd == 3'd3 || cur.cmd == 3'd4) m_phase = 2;
               else begin done = 1; m_phase = 0; end
            end
         default: if (en_ok) begin done = 1; m_phase = 0; end
      endcase
      if (cpu_req_valid_i) begin
         if (pre_size < DEPTH) mq.push_back('{cmd: cpu_req_cmd_i, addr: cpu_req_addr_i});
         else e_err = 1;
      end
      e_done = done;
      e_ready = (mq.size() < DEPTH);
   endtask

   initial begin
      cyc = 0;
      model_reset();
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else model_step();
   end

   always @(negedge clk) begin
      if (rst && run_cmp) begin
         chk("ready", cpu_req_ready_o, e_ready);
         chk("done", cpu_done_o, e_done);
         chk("mbus_cmd", mbus_cmd_o, e_mcmd);
         chk("mbus_addr", mbus_addr_o, e_maddr);
         chk("cbus_ack", cbus_ack_o, e_ack);
         chk("snoop_valid", snoop_valid_o, e_sv);
         chk("snoop_wr", snoop_wr_o, e_swr);
         chk("snoop_addr", snoop_addr_o, e_saddr);
         chk("protocol_err", protocol_err_o, e_err);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_req(input logic [2:0] c, input logic [31:0] a);
      cpu_req_valid_i = 1'b1;
      cpu_req_cmd_i = c;
      cpu_req_addr_i = a;
      @(negedge clk);
      cpu_req_valid_i = 1'b0;
   endtask

   task automatic send_cbus(input logic [2:0] c, input logic [31:0] a,
                            output int lat, output bit sv, output bit swr,
                            output bit dn);
      cbus_cmd_i = c;
      cbus_addr_i = a;
      lat = 0; sv = 0; swr = 0; dn = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (snoop_valid_o) begin sv = 1; swr = snoop_wr_o; end
         if (cbus_ack_o) begin lat = i; dn = cpu_done_o; break; end
      end
      cbus_cmd_i = 3'd0;
      if (lat == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL cbus_ack_timeout: got none expected ack within 20 cycles");
      end
   endtask

   int lat;
   bit sv, swr, dn;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ready", cpu_req_ready_o, 1);
      chk("rst_mbus_cmd", mbus_cmd_o, 0);
      chk("rst_err", protocol_err_o, 0);
      chk("rst_cbus_ack", cbus_ack_o, 0);
      rst = 1'b1;
      run_cmp = 1'b1;
      @(negedge clk);

      // plain RD, ack two cycles after issue
      push_req(3'd2, 32'h100);
      @(negedge clk);
      chk("rd_issue_cmd", mbus_cmd_o, 3'd2);
      chk("rd_issue_addr", mbus_addr_o, 32'h100);
      @(negedge clk);
      chk("rd_hold_cmd", mbus_cmd_o, 3'd2);
      mbus_ack_i = 1'b1;
      @(negedge clk);
      mbus_ack_i = 1'b0;
      chk("rd_nop_after_ack", mbus_cmd_o, 3'd0);
      chk("rd_done_pulse", cpu_done_o, 1);
      @(negedge clk);
      chk("rd_done_once", cpu_done_o, 0);

      // WR_BROAD then matching EN_WR
      push_req(3'd3, 32'h200);
      @(negedge clk);
      chk("wrb_issue_cmd", mbus_cmd_o, 3'd3);
      mbus_ack_i = 1'b1;
      @(negedge clk);
      mbus_ack_i = 1'b0;
      chk("wrb_nop", mbus_cmd_o, 3'd0);
      chk("wrb_no_done_yet", cpu_done_o, 0);
      send_cbus(3'd3, 32'h200, lat, sv, swr, dn);
      chk("en_wr_lat", lat, 1);
      chk("en_wr_done", dn, 1);
      chk("en_wr_no_err", protocol_err_o, 0);

      // snoop while waiting for EN
      push_req(3'd4, 32'h240);
      @(negedge clk);
      mbus_ack_i = 1'b1;
      @(negedge clk);
      mbus_ack_i = 1'b0;
      send_cbus(3'd2, 32'h300, lat, sv, swr, dn);
      chk("snoop_lat", lat, L);
      chk("snoop_valid_seen", sv, 1);
      chk("snoop_is_rd", swr, 0);
      chk("snoop_addr", snoop_addr_o, 32'h300);
      chk("snoop_no_done", dn, 0);
      chk("snoop_mbus_nop", mbus_cmd_o, 3'd0);
      send_cbus(3'd4, 32'h240, lat, sv, swr, dn);
      chk("en_rd_after_gap_lat", lat, 3);
      chk("en_rd_done", dn, 1);
      chk("no_err_yet", protocol_err_o, 0);

      // overflow with ack held low
      push_req(3'd1, 32'h500);
      @(negedge clk);
      chk("ovf_busy_cmd", mbus_cmd_o, 3'd1);
      cpu_req_valid_i = 1'b1;
      cpu_req_cmd_i = 3'd2;
      cpu_req_addr_i = 32'h510;
      @(negedge clk);
      chk("ovf_ready_1", cpu_req_ready_o, 1);
      cpu_req_addr_i = 32'h520;
      @(negedge clk);
      chk("ovf_full", cpu_req_ready_o, 0);
      chk("ovf_err_before", protocol_err_o, 0);
      cpu_req_addr_i = 32'h530;
      @(negedge clk);
      cpu_req_valid_i = 1'b0;
      chk("ovf_err_set", protocol_err_o, 1);
      chk("ovf_still_full", cpu_req_ready_o, 0);

      // reset during M_REQ
      #2 rst = 1'b0;
      #1;
      chk("rst_async_cmd", mbus_cmd_o, 3'd0);
      chk("rst_async_ready", cpu_req_ready_o, 1);
      chk("rst_async_err", protocol_err_o, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_no_req", mbus_cmd_o, 3'd0);
      @(negedge clk);
      chk("post_rst_empty", cpu_req_ready_o, 1);
      chk("post_rst_no_req2", mbus_cmd_o, 3'd0);

      // EN with nothing outstanding
      send_cbus(3'd4, 32'h400, lat, sv, swr, dn);
      chk("stray_en_lat", lat, 1);
      chk("stray_en_no_done", dn, 0);
      chk("stray_en_err", protocol_err_o, 1);

      // randomised traffic
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (i == 1500) begin
            rst = 1'b0;
            cpu_req_valid_i = 1'b0;
            cbus_cmd_i = 3'd0;
            mbus_ack_i = 1'b0;
            repeat (2) @(negedge clk);
            rst = 1'b1;
         end
         cpu_req_valid_i = ($urandom_range(0, 2) == 0);
         cpu_req_cmd_i = 3'($urandom_range(1, 4));
         cpu_req_addr_i = 32'h100 + 32'($urandom_range(0, 3)) * 32'h10;
         mbus_ack_i = ($urandom_range(0, 1) == 1);
         if (m_phase == 2 && $urandom_range(0, 2) == 0) begin
            cbus_cmd_i = (cur.cmd == 3'd3) ? 3'd3 : 3'd4;
            cbus_addr_i = cur.addr;
         end else if ($urandom_range(0, 3) == 0) begin
            cbus_cmd_i = 3'($urandom_range(1, 4));
            cbus_addr_i = 32'h100 + 32'($urandom_range(0, 3)) * 32'h10;
         end else begin
            cbus_cmd_i = 3'd0;
         end
      end
      @(negedge clk);
      cpu_req_valid_i = 1'b0;
      cbus_cmd_i = 3'd0;
      mbus_ack_i = 1'b0;
      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
